// File: rtl/memc_deskew.sv
// rtl/memc_deskew.sv - result-side deskew collector and DIM x DIM row store for the tpumac systolic array
//
// Optional build macro: MEMC_DESKEW_RDREG_EN
//   undefined (default): Cout = store[Crow] combinationally; a same-cycle write returns the old row.
//   defined            : Cout is registered and shows store[Crow] one cycle after Crow is presented.
//
// Lane i of Cin carries column i of the result, skewed by i cycles relative to lane 0.
// Lane i is delayed by DIM-1-i registers so that all lanes of result row k line up at
// cnt = k+DIM-1, at which point the aligned vector is written to store row k.

module memc_deskew #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic signed [DIM-1:0][BITS_C-1:0]     Cin,
  input  logic        [$clog2(DIM)-1:0]         Crow,
  output logic signed [DIM-1:0][BITS_C-1:0]     Cout,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  full
);

  localparam int CW = $clog2(2 * DIM);
  localparam int RW = $clog2(DIM);

  // Last count value of a capture: row DIM-1 is written here.
  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * DIM - 2);
  // First count value at which an aligned row is available (row 0).
  localparam logic [CW-1:0] CNT_FIRST = CW'(DIM - 1);

  typedef enum logic {
    S_IDLE,
    S_CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;

  logic            capture_en;
  logic            wr_en;
  logic [RW-1:0]   wr_row;

  // Deskewed row presented to the store in the current cycle.
  logic [DIM-1:0][BITS_C-1:0] aligned;

  // Result store: one packed row of DIM elements per entry.
  logic [DIM-1:0][BITS_C-1:0] store_q [DIM];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State, capture counter and full flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE, so a pulse during a
  // capture neither restarts nor extends it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    capture_en = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          full_d  = 1'b1;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == S_CAPTURE);
  assign full = full_q;

  // Writes only occur while an aligned row exists, so lane values outside
  // their valid window can never reach the store.
  assign wr_en  = capture_en && (cnt_q >= CNT_FIRST);
  assign wr_row = RW'(cnt_q - CNT_FIRST);

  // ---------------------------------------------------------------------------
  // Per-lane deskew chains
  // ---------------------------------------------------------------------------

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam int DEPTH = DIM - 1 - i;

    if (DEPTH == 0) begin : g_direct
      // The most-skewed lane arrives last and needs no delay.
      assign aligned[i] = Cin[i];
    end else begin : g_chain
      logic [BITS_C-1:0] sh_q [DEPTH];

      // Shift chain advances only during a capture so that the chain contents
      // always come from the current capture's input window.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DEPTH; j++) begin
            sh_q[j] <= '0;
          end
        end else if (capture_en) begin
          sh_q[0] <= Cin[i];
          for (int j = 1; j < DEPTH; j++) begin
            sh_q[j] <= sh_q[j-1];
          end
        end
      end

      assign aligned[i] = sh_q[DEPTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result store
  // ---------------------------------------------------------------------------

  // Row write; reset clears every row so an aborted capture leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        store_q[r] <= '0;
      end
    end else if (wr_en) begin
      store_q[wr_row] <= aligned;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------

`ifdef MEMC_DESKEW_RDREG_EN
  logic [DIM-1:0][BITS_C-1:0] cout_q;

  // Registered read of the store; a write landing this cycle is seen by the
  // read of the next cycle and therefore appears on Cout two cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= '0;
    end else begin
      cout_q <= store_q[Crow];
    end
  end

  assign Cout = cout_q;
`else
  // Combinational read; a row being written this cycle still returns its old contents.
  assign Cout = store_q[Crow];
`endif

endmodule

// File: tb/tb_memc_deskew.sv
// tb/tb_memc_deskew.sv - directed self-checking bench for memc_deskew (DIM=8, BITS_C=16)

module tb_memc_deskew;

  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int VW     = DIM * BITS_C;
  localparam logic [BITS_C-1:0] GARBAGE = 16'hDEAD;

`ifdef MEMC_DESKEW_RDREG_EN
  localparam int NEW_AT = 12;
`else
  localparam int NEW_AT = 11;
`endif

  logic                              clk;
  logic                              rst;
  logic                              start;
  logic signed [DIM-1:0][BITS_C-1:0] cin;
  logic        [$clog2(DIM)-1:0]     crow;
  logic signed [DIM-1:0][BITS_C-1:0] cout;
  logic                              busy;
  logic                              done;
  logic                              full;

  int n_assert;
  int n_fail;

  memc_deskew #(
    .BITS_C (BITS_C),
    .DIM    (DIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Cin   (cin),
    .Crow  (crow),
    .Cout  (cout),
    .busy  (busy),
    .done  (done),
    .full  (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode 0: 16k+i, mode 1: -(k+1)(i+1), mode 2: all zero
  function automatic logic [BITS_C-1:0] cval(input int mode, input int k, input int i);
    int v;
    case (mode)
      0:       v = 16 * k + i;
      1:       v = -(k + 1) * (i + 1);
      default: v = 0;
    endcase
    return BITS_C'(v);
  endfunction

  function automatic logic [VW-1:0] row_vec(input int mode, input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*BITS_C +: BITS_C] = cval(mode, r, i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input int mode, input string tag);
    logic dead;
    for (int r = 0; r < DIM; r++) begin
      crow = r[$clog2(DIM)-1:0];
      @(negedge clk);
      chk($sformatf("%s_row%0d", tag, r), cout, row_vec(mode, r));
      dead = 1'b0;
      for (int i = 0; i < DIM; i++) if (cout[i] === GARBAGE) dead = 1'b1;
      chk($sformatf("%s_nodead%0d", tag, r), VW'(dead), VW'(1'b0));
    end
  endtask

  // Runs one capture with Crow held at 3. abort_at/restart_at of -1 disable those events.
  // prev_mode is the content of row 3 before this capture, checked around its write.
  task automatic capture(input int mode, input int prev_mode, input int abort_at,
                         input int restart_at, input string tag);
    int done_cnt;
    done_cnt = 0;
    crow  = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2 * DIM - 1; c++) begin
      for (int i = 0; i < DIM; i++) begin
        if (c - i >= 0 && c - i < DIM) cin[i] = cval(mode, c - i, i);
        else                           cin[i] = GARBAGE;
      end
      start = (c == restart_at);
      if (busy !== 1'b1) chk($sformatf("%s_busy_c%0d", tag, c), VW'(busy), VW'(1'b1));
      if (done === 1'b1) done_cnt++;
      if (c == 0)  chk({tag, "_full_cleared"}, VW'(full), VW'(1'b0));
      if (c == 14) chk({tag, "_done_at14"}, VW'(done), VW'(1'b1));
      if (c >= 10 && c <= NEW_AT)
        chk($sformatf("%s_coll_c%0d", tag, c), cout,
            (c < NEW_AT) ? row_vec(prev_mode, 3) : row_vec(mode, 3));
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < DIM; i++) cin[i] = GARBAGE;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < DIM; i++) cin[i] = GARBAGE;
    chk({tag, "_done_count"}, VW'(done_cnt), VW'(1));
    chk({tag, "_busy_after"}, VW'(busy), VW'(1'b0));
    chk({tag, "_done_after"}, VW'(done), VW'(1'b0));
    chk({tag, "_full_after"}, VW'(full), VW'(1'b1));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    crow     = '0;
    for (int i = 0; i < DIM; i++) cin[i] = GARBAGE;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", VW'(busy), VW'(1'b0));
    chk("rst_done", VW'(done), VW'(1'b0));
    chk("rst_full", VW'(full), VW'(1'b0));
    chk("rst_cout", cout, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic capture over a zeroed store
    capture(0, 2, -1, -1, "basic");
    check_rows(0, "basic");

    // Signed data, with a spurious start at cnt=5
    capture(1, 0, -1, 5, "signed");
    check_rows(1, "signed");
    crow = 7;
    @(negedge clk);
    chk("signed_r7l7", VW'(cout[7]), VW'(16'hFFC0));

    // Reset in the middle of a capture
    capture(0, 1, 9, -1, "abort");
    chk("abort_busy", VW'(busy), VW'(1'b0));
    chk("abort_full", VW'(full), VW'(1'b0));
    chk("abort_done", VW'(done), VW'(1'b0));
    check_rows(2, "abort");

    // Fresh capture after the abort
    capture(1, 2, -1, -1, "recap");
    check_rows(1, "recap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
